// File: rtl/ipif_request_arbiter_pkg.sv
// Shared types and helpers for the IPIF request arbiter: FSM states, response
// record and index-width helper.
package ipif_request_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP
    } state_t;

    // Response data field is sized for the widest supported bus; the top slices it down.
    localparam int RSP_DATA_W = 64;

    typedef struct packed {
        logic                  err;
        logic [RSP_DATA_W-1:0] data;
    } rsp_t;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ipif_request_arbiter_if.sv
// IPIF bus between the arbiter (master side) and the register-bank slave.
interface ipif_request_arbiter_if #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int N_REG = 2
);
    logic [AW-1:0]    IPIF_bus2ip_addr;
    logic [DW-1:0]    IPIF_bus2ip_data;
    logic [N_REG-1:0] IPIF_bus2ip_rdce;
    logic [N_REG-1:0] IPIF_bus2ip_wrce;
    logic             IPIF_bus2ip_wstrb;
    logic [DW-1:0]    IPIF_ip2bus_data;
    logic             IPIF_ip2bus_rdack;
    logic             IPIF_ip2bus_wrack;

    modport master (
        output IPIF_bus2ip_addr, IPIF_bus2ip_data, IPIF_bus2ip_rdce,
               IPIF_bus2ip_wrce, IPIF_bus2ip_wstrb,
        input  IPIF_ip2bus_data, IPIF_ip2bus_rdack, IPIF_ip2bus_wrack
    );

    modport slave (
        input  IPIF_bus2ip_addr, IPIF_bus2ip_data, IPIF_bus2ip_rdce,
               IPIF_bus2ip_wrce, IPIF_bus2ip_wstrb,
        output IPIF_ip2bus_data, IPIF_ip2bus_rdack, IPIF_ip2bus_wrack
    );
endinterface

// File: rtl/ipif_request_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request after the last
// granted index, wrapping, and reports it one-hot and encoded.
module rr_arbiter
    import ipif_request_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // Scan starts one past the last winner so the last winner is checked last.
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/ipif_request_arbiter.sv
// Shares one IPIF register-bank slave between N_REQ requesters: round-robin
// grant, word-address CE decode, ack wait with timeout, response to the owner.
module ipif_request_arbiter
    import ipif_request_arbiter_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int N_REG              = 2,
    parameter int N_REQ              = 2,
    parameter int TIMEOUT            = 15
) (
    input  logic                                         clk,
    input  logic                                         IPIF_bus2ip_resetn,
    input  logic [N_REQ-1:0]                             req_valid,
    output logic [N_REQ-1:0]                             req_ready,
    input  logic [N_REQ-1:0]                             req_wr,
    input  logic [N_REQ-1:0][C_S_AXI_ADDR_WIDTH-1:0]     req_addr,
    input  logic [N_REQ-1:0][C_S_AXI_DATA_WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]                             rsp_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                rsp_data,
    output logic                                         rsp_err,
    ipif_request_arbiter_if.master                       ipif
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int REQ_IW = idx_width(N_REQ);
    localparam int REG_IW = idx_width(N_REG);
    localparam int TMR_W  = idx_width(TIMEOUT);

    state_t            state_q, state_d;
    logic [REQ_IW-1:0] ptr_q, owner_q, grant_idx;
    logic [N_REQ-1:0]  grant;
    logic              wr_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     data_q;
    logic [N_REG-1:0]  rdce_q, wrce_q;
    logic              wstrb_q;
    logic [TMR_W-1:0]  timer_q;
    logic [N_REQ-1:0]  rsp_valid_q;
    rsp_t              rsp_q;

    logic              accept, ack_hit, timed_out;
    logic              sel_wr, sel_in_range;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_data;
    logic [AW-3:0]     sel_word;
    logic [N_REG-1:0]  sel_ce;

    rr_arbiter #(.N(N_REQ), .IW(REQ_IW)) u_rr (
        .req       (req_valid),
        .last      (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Decode of the granted request; byte-offset bits are ignored for the CE.
    assign sel_wr       = req_wr[grant_idx];
    assign sel_addr     = req_addr[grant_idx];
    assign sel_data     = req_data[grant_idx];
    assign sel_word     = sel_addr[AW-1:2];
    assign sel_in_range = (sel_word < (AW-2)'(N_REG));
    assign sel_ce       = N_REG'(1) << sel_word[REG_IW-1:0];

    always_ff @(posedge clk) begin
        if (!IPIF_bus2ip_resetn) state_q <= IDLE;
        else                     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                accept    = |grant;
                if (accept) state_d = sel_in_range ? BUS : GAP;
            end
            BUS: begin
                // Only the ack matching the transaction direction completes it.
                ack_hit   = wr_q ? ipif.IPIF_ip2bus_wrack : ipif.IPIF_ip2bus_rdack;
                timed_out = !ack_hit && (timer_q == TMR_W'(TIMEOUT-1));
                if (ack_hit || timed_out) state_d = GAP;
            end
            // Dead cycle absorbs the ack the slave registers from the last CE cycle.
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!IPIF_bus2ip_resetn) begin
            ptr_q       <= REQ_IW'(N_REQ-1);
            owner_q     <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rdce_q      <= '0;
            wrce_q      <= '0;
            wstrb_q     <= 1'b0;
            timer_q     <= '0;
            rsp_valid_q <= '0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= '0;
            rsp_q       <= '0;
            if (accept) begin
                ptr_q   <= grant_idx;
                owner_q <= grant_idx;
                wr_q    <= sel_wr;
                addr_q  <= sel_addr;
                data_q  <= sel_data;
                timer_q <= '0;
                if (sel_in_range) begin
                    rdce_q  <= sel_wr ? '0 : sel_ce;
                    wrce_q  <= sel_wr ? sel_ce : '0;
                    wstrb_q <= sel_wr;
                end else begin
                    rsp_valid_q <= grant;
                    rsp_q.err   <= 1'b1;
                end
            end
            if (ack_hit || timed_out) begin
                rdce_q      <= '0;
                wrce_q      <= '0;
                wstrb_q     <= 1'b0;
                rsp_valid_q <= N_REQ'(1) << owner_q;
                rsp_q.err   <= timed_out;
                rsp_q.data  <= (ack_hit && !wr_q) ? RSP_DATA_W'(ipif.IPIF_ip2bus_data) : '0;
            end else if (state_q == BUS) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign rsp_valid              = rsp_valid_q;
    assign rsp_err                = rsp_q.err;
    assign rsp_data               = rsp_q.data[DW-1:0];
    assign ipif.IPIF_bus2ip_addr  = addr_q;
    assign ipif.IPIF_bus2ip_data  = data_q;
    assign ipif.IPIF_bus2ip_rdce  = rdce_q;
    assign ipif.IPIF_bus2ip_wrce  = wrce_q;
    assign ipif.IPIF_bus2ip_wstrb = wstrb_q;
endmodule
